// File: rtl/heartbeat_pkg.sv
// Shared types for the heartbeat monitor.
//   hb_state_t : monitor FSM state encoding (IDLE / TRACK / LOST)
package heartbeat_pkg;

  typedef enum logic [1:0] {
    HB_IDLE  = 2'd0,
    HB_TRACK = 2'd1,
    HB_LOST  = 2'd2
  } hb_state_t;

endpackage

// File: rtl/heartbeat_edge_detect.sv
// Rising-edge detector for the heartbeat input, with an optional 2-flop
// synchronizer in front when HEARTBEAT_MONITOR_SYNC_EN is defined.
// Ports:
//   clk    : clock
//   nreset : async active-low reset
//   hb_in  : raw heartbeat input
//   e      : 1-cycle rising-edge pulse (combinational from hb_s and hb_q)
module heartbeat_edge_detect (
  input  logic clk,
  input  logic nreset,
  input  logic hb_in,
  output logic e
);

  logic hb_s;
  logic hb_q;

`ifdef HEARTBEAT_MONITOR_SYNC_EN
  // Two-stage synchronizer; hb_in may be asynchronous to clk.
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], hb_in};
    end
  end

  assign hb_s = sync_q[1];
`else
  assign hb_s = hb_in;
`endif

  // Previous-cycle copy of the conditioned input.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hb_q <= 1'b0;
    end else begin
      hb_q <= hb_s;
    end
  end

  assign e = hb_s & ~hb_q;

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: checks that a pulse train arrives every 2^N clocks
// within +/-TOL, flags early and missing beats, and declares the source lost
// after LOSS_CNT consecutive misses.
// Build option: HEARTBEAT_MONITOR_SYNC_EN inserts a 2-flop input synchronizer.
// Ports:
//   clk, nreset : clock, async active-low reset
//   vpp, gnd    : supply pins, no logic function
//   hb_in       : heartbeat input
//   clear       : synchronous clear of err_count
//   alive, lost : FSM status (TRACK / LOST)
//   early_err   : 1-cycle pulse, edge before P-TOL
//   late_err    : 1-cycle pulse, no edge by P+TOL
//   period      : last accepted edge-to-edge interval
//   err_count   : saturating early+late error count
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned TOL      = 2,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERRW     = 8
) (
  input  logic            clk,
  input  logic            nreset,
  inout  wire             vpp,
  inout  wire             gnd,
  input  logic            hb_in,
  input  logic            clear,
  output logic            alive,
  output logic            lost,
  output logic            early_err,
  output logic            late_err,
  output logic [N+1:0]    period,
  output logic [ERRW-1:0] err_count
);

  localparam int unsigned CW    = N + 2;
  localparam int unsigned MW    = $clog2(LOSS_CNT + 1);
  localparam int unsigned P     = 1 << N;
  localparam int unsigned P_MIN = P - TOL;
  localparam int unsigned P_MAX = P + TOL;

  // Supply pins carry no logic; fold them into a sink.
  logic unused_ok;
  assign unused_ok = &{1'b0, vpp, gnd};

  logic            e;
  hb_state_t       state;
  hb_state_t       state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [MW-1:0]   miss;
  logic [MW-1:0]   miss_next;
  logic [CW-1:0]   period_next;
  logic            early_next;
  logic            late_next;
  logic            err_hit;
  logic [ERRW-1:0] err_count_next;

  heartbeat_edge_detect u_edge (
    .clk    (clk),
    .nreset (nreset),
    .hb_in  (hb_in),
    .e      (e)
  );

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= HB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, counter updates and error pulses.
  always_comb begin
    state_next  = state;
    cnt_next    = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    miss_next   = miss;
    period_next = period;
    early_next  = 1'b0;
    late_next   = 1'b0;
    err_hit     = 1'b0;

    unique case (state)
      HB_IDLE, HB_LOST: begin
        if (e) begin
          cnt_next   = CW'(1);
          miss_next  = '0;
          state_next = HB_TRACK;
        end
      end
      HB_TRACK: begin
        if (e) begin
          cnt_next = CW'(1);
          if (cnt < CW'(P_MIN)) begin
            early_next = 1'b1;
            err_hit    = 1'b1;
          end else begin
            period_next = cnt;
            miss_next   = '0;
          end
        end else if (cnt == CW'(P_MAX)) begin
          // Missed beat: re-arm as if the beat had landed exactly at P.
          late_next = 1'b1;
          err_hit   = 1'b1;
          miss_next = miss + MW'(1);
          cnt_next  = CW'(TOL + 1);
          if (miss + MW'(1) == MW'(LOSS_CNT)) begin
            state_next = HB_LOST;
          end
        end
      end
      default: begin
        state_next = HB_IDLE;
      end
    endcase
  end

  // clear dominates a same-cycle error.
  always_comb begin
    err_count_next = err_count;
    if (clear) begin
      err_count_next = '0;
    end else if (err_hit && (err_count != {ERRW{1'b1}})) begin
      err_count_next = err_count + ERRW'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt       <= '0;
      miss      <= '0;
      period    <= '0;
      early_err <= 1'b0;
      late_err  <= 1'b0;
      alive     <= 1'b0;
      lost      <= 1'b0;
      err_count <= '0;
    end else begin
      cnt       <= cnt_next;
      miss      <= miss_next;
      period    <= period_next;
      early_err <= early_next;
      late_err  <= late_next;
      alive     <= (state_next == HB_TRACK);
      lost      <= (state_next == HB_LOST);
      err_count <= err_count_next;
    end
  end

endmodule
